// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Pixel-timing master for the VGA path. Free-running horizontal and vertical
// counters produce DrawX/DrawY/blank for the sprite/background renderer. The
// renderer's RGB comes back PIPE_DLY cycles later. That RGB is blanked and
// registered toward the DAC. hs/vs are delayed by the same amount so that the
// sync pulses line up with the pixels they belong to. A one-cycle frame_start
// pulse and a wrapping frame_count pace the game logic, such as snake motion
// and obstacle respawn.
//
// Ports
//   Clk          in   1   pixel clock; also feeds the renderer
//   reset        in   1   synchronous, active-high
//   red_in       in   4   renderer red, valid PIPE_DLY cycles after DrawX/DrawY
//   green_in     in   4   renderer green
//   blue_in      in   4   renderer blue
//   DrawX        out  10  horizontal count, 0..H_TOTAL-1
//   DrawY        out  10  vertical count, 0..V_TOTAL-1
//   blank        out  1   1 = visible pixel, 0 = blanking (combinational)
//   hs           out  1   horizontal sync, aligned with vga_*
//   vs           out  1   vertical sync, aligned with vga_*
//   vga_r/g/b    out  4   blanked colour to the DAC
//   frame_start  out  1   one-cycle pulse at the start of vertical blanking
//   frame_count  out  16  frames completed, wraps
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int PIPE_DLY  = 1
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    // Both totals must fit the 10-bit counters, so each must be <= 1024.
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = V_VISIBLE + V_FP + V_SYNC;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    // Pipeline word is {hs, vs, blank}. The idle word is syncs off and not visible.
    localparam logic [2:0] PIPE_IDLE = {SYNC_OFF, SYNC_OFF, 1'b0};

    logic [9:0] h_count;
    logic [9:0] v_count;
    int         h_pos;
    int         v_pos;
    logic       hs_raw;
    logic       vs_raw;
    logic       frame_edge;
    logic [2:0] pipe [PIPE_DLY];
    logic [2:0] pipe_out;

    // Free-running raster counters. The line counter advances only when the
    // pixel counter wraps.
    always_ff @(posedge Clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_MAX) begin
            h_count <= '0;
            v_count <= (v_count == V_MAX) ? 10'd0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    assign DrawX = h_count;
    assign DrawY = v_count;

    // The decodes compare as signed ints. Degenerate parameter sets, such as a
    // zero-line visible area, then produce no constant unsigned comparisons.
    always_comb begin
        h_pos      = int'(h_count);
        v_pos      = int'(v_count);
        blank      = (h_pos < H_VISIBLE) && (v_pos < V_VISIBLE);
        hs_raw     = (h_pos >= HS_START && h_pos < HS_END) ? SYNC_ON : SYNC_OFF;
        vs_raw     = (v_pos >= VS_START && v_pos < VS_END) ? SYNC_ON : SYNC_OFF;
        frame_edge = (h_count == 10'd0) && (v_pos == V_VISIBLE);
    end

    // Delay line matching the renderer latency. On reset it is flushed with
    // idle words, so no sync fragment leaks out when reset is entered or left.
    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                pipe[i] <= PIPE_IDLE;
            end
        end else begin
            pipe[0] <= {hs_raw, vs_raw, blank};
            for (int i = 1; i < PIPE_DLY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign pipe_out = pipe[PIPE_DLY-1];

    // Output stage. At this point the delayed blank lines up with the
    // renderer colour that belongs to the same pixel.
    always_ff @(posedge Clk) begin
        if (reset) begin
            hs    <= SYNC_OFF;
            vs    <= SYNC_OFF;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            hs    <= pipe_out[2];
            vs    <= pipe_out[1];
            vga_r <= pipe_out[0] ? red_in   : 4'd0;
            vga_g <= pipe_out[0] ? green_in : 4'd0;
            vga_b <= pipe_out[0] ? blue_in  : 4'd0;
        end
    end

    // Frame pacing. The pulse and the count update on the edge after the
    // raster enters the first line of vertical blanking.
    always_ff @(posedge Clk) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= frame_edge;
            if (frame_edge) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen using three instances:
//   dut_a - default 640x480 timing; covers reset state, line timing and video.
//   dut_s - small 16x8 raster (total 24x14); covers frame pacing, vertical
//           blanking and reset during active syncs.
//   dut_w - single-pixel raster with a frame every cycle; covers the wrap
//           of frame_count.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    always #20 Clk = ~Clk;

    logic [3:0] red_in, green_in, blue_in;
    logic reset_a, reset_s, reset_w;

    logic [9:0]  x_a, y_a, x_s, y_s, x_w, y_w;
    logic        blank_a, hs_a, vs_a, fs_a;
    logic        blank_s, hs_s, vs_s, fs_s;
    logic        blank_w, hs_w, vs_w, fs_w;
    logic [3:0]  r_a, g_a, b_a, r_s, g_s, b_s, r_w, g_w, b_w;
    logic [15:0] fc_a, fc_s, fc_w;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen dut_a (
        .Clk(Clk), .reset(reset_a),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .DrawX(x_a), .DrawY(y_a), .blank(blank_a), .hs(hs_a), .vs(vs_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
        .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_s (
        .Clk(Clk), .reset(reset_s),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .DrawX(x_s), .DrawY(y_s), .blank(blank_s), .hs(hs_s), .vs(vs_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .frame_start(fs_s), .frame_count(fc_s)
    );

    vga_timing_gen #(
        .H_VISIBLE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_VISIBLE(0), .V_FP(0), .V_SYNC(0), .V_BP(1)
    ) dut_w (
        .Clk(Clk), .reset(reset_w),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .DrawX(x_w), .DrawY(y_w), .blank(blank_w), .hs(hs_w), .vs(vs_w),
        .vga_r(r_w), .vga_g(g_w), .vga_b(b_w),
        .frame_start(fs_w), .frame_count(fc_w)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ra, input logic rs, input logic rw);
        reset_a = ra;
        reset_s = rs;
        reset_w = rw;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int hs_first, hs_low, vs_low_a, pos_err, mx, my;
        int vid_line0, dark_line0, vid_line1;
        int first_pulse, second_pulse, pulses, vs_low, vs_first, vid_f, vid_blank;
        logic found;

        red_in   = 4'hF;
        green_in = 4'hA;
        blue_in  = 4'h5;
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (3) tick();

        // Reset state of the default instance
        checkOutput("rst DrawX", 32'(x_a), 32'd0);
        checkOutput("rst DrawY", 32'(y_a), 32'd0);
        checkOutput("rst blank", 32'(blank_a), 32'd1);
        checkOutput("rst hs", 32'(hs_a), 32'd1);
        checkOutput("rst vs", 32'(vs_a), 32'd1);
        checkOutput("rst vga", 32'({r_a, g_a, b_a}), 32'd0);
        checkOutput("rst frame_start", 32'(fs_a), 32'd0);
        checkOutput("rst frame_count", 32'(fc_a), 32'd0);

        // Two full lines on the default instance
        applyStimulus(1'b0, 1'b1, 1'b1);
        hs_first = -1; hs_low = 0; vs_low_a = 0; pos_err = 0; mx = 0; my = 0;
        vid_line0 = 0; dark_line0 = 0; vid_line1 = 0;
        for (int k = 1; k <= 1600; k++) begin
            tick();
            mx++;
            if (mx == 800) begin
                mx = 0;
                my++;
            end
            if (x_a !== 10'(mx) || y_a !== 10'(my) ||
                blank_a !== ((mx < 640) && (my < 480)))
                pos_err++;
            if (vs_a !== 1'b1 || fs_a !== 1'b0) vs_low_a++;
            if (k == 1) checkOutput("vga after release", 32'({r_a, g_a, b_a}), 32'd0);
            if (k == 2) checkOutput("first pixel", 32'({r_a, g_a, b_a}), 32'hFA5);
            if (k == 799) checkOutput("x at 799", 32'({y_a, x_a}), 32'd799);
            if (k == 800) checkOutput("line wrap", 32'({y_a, x_a}), 32'h400);
            if (k <= 800) begin
                if (hs_a == 1'b0) begin
                    if (hs_first < 0) hs_first = k;
                    hs_low++;
                end
                if ({r_a, g_a, b_a} == 12'hFA5) vid_line0++;
                else if ({r_a, g_a, b_a} == 12'h000) dark_line0++;
            end else if ({r_a, g_a, b_a} == 12'hFA5) begin
                vid_line1++;
            end
        end
        checkOutput("raster model", 32'(pos_err), 32'd0);
        checkOutput("hs first low", 32'(hs_first), 32'd658);
        checkOutput("hs low width", 32'(hs_low), 32'd96);
        checkOutput("no vs/frame in line 0-1", 32'(vs_low_a), 32'd0);
        checkOutput("video line 0", 32'(vid_line0), 32'd640);
        checkOutput("dark line 0", 32'(dark_line0), 32'd160);
        checkOutput("video line 1", 32'(vid_line1), 32'd640);

        // Frame pacing on the small raster (frame = 24*14 = 336 cycles)
        applyStimulus(1'b0, 1'b0, 1'b1);
        first_pulse = -1; second_pulse = -1; pulses = 0;
        vs_low = 0; vs_first = -1; vid_f = 0; vid_blank = 0;
        for (int k = 1; k <= 900; k++) begin
            tick();
            if (fs_s) begin
                pulses++;
                if (first_pulse < 0) first_pulse = k;
                else if (second_pulse < 0) second_pulse = k;
            end
            if (k == 192) checkOutput("fc before frame", 32'(fc_s), 32'd0);
            if (k == 193) checkOutput("fc first frame", 32'(fc_s), 32'd1);
            if (k <= 336) begin
                if (vs_s == 1'b0) begin
                    if (vs_first < 0) vs_first = k;
                    vs_low++;
                end
                if ({r_s, g_s, b_s} == 12'hFA5) vid_f++;
                if (k >= 195 && {r_s, g_s, b_s} != 12'h000) vid_blank++;
            end
        end
        checkOutput("first frame_start", 32'(first_pulse), 32'd193);
        checkOutput("frame interval", 32'(second_pulse - first_pulse), 32'd336);
        checkOutput("pulse cycles", 32'(pulses), 32'd3);
        checkOutput("fc after 3 frames", 32'(fc_s), 32'd3);
        checkOutput("vs first low", 32'(vs_first), 32'd242);
        checkOutput("vs low width", 32'(vs_low), 32'd48);
        checkOutput("video per frame", 32'(vid_f), 32'd128);
        checkOutput("video in vblank", 32'(vid_blank), 32'd0);

        // Reset while both syncs are active (DrawX=20, DrawY=11)
        found = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (x_s == 10'd20 && y_s == 10'd11) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("reach sync point", 32'(found), 32'd1);
        if (found) begin
            checkOutput("hs active pre-reset", 32'(hs_s), 32'd0);
            checkOutput("vs active pre-reset", 32'(vs_s), 32'd0);
            applyStimulus(1'b0, 1'b1, 1'b1);
            tick();
            checkOutput("mid reset xy", 32'({y_s, x_s}), 32'd0);
            checkOutput("mid reset syncs", 32'({hs_s, vs_s}), 32'd3);
            checkOutput("mid reset fc", 32'(fc_s), 32'd0);
            checkOutput("mid reset vga/fs", 32'({r_s, g_s, b_s, fs_s}), 32'd0);
            applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
            tick();
            checkOutput("post reset syncs", 32'({hs_s, vs_s}), 32'd3);
            checkOutput("post reset x", 32'(x_s), 32'd2);
        end

        // frame_count wrap: one frame per cycle on the single-pixel raster
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 65537; k++) begin
            tick();
            if (k == 1) checkOutput("wrap first frame", 32'({fs_w, fc_w}), 32'h10001);
            if (k == 65535) checkOutput("fc at FFFF", 32'(fc_w), 32'hFFFF);
            if (k == 65536) checkOutput("fc wraps", 32'({fs_w, fc_w}), 32'h10000);
            if (k == 65537) checkOutput("fc after wrap", 32'(fc_w), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
